// File: rtl/seg_display_driver_pkg.sv
// Shared constants for the 7-segment display driver: digit width, blank code
// and the hex-to-segment table. Segment bit order is {g,f,e,d,c,b,a}, 1 = lit.
package seg_display_driver_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex_to_seg(input logic [DIGIT_W-1:0] hex);
    logic [6:0] code;
    unique case (hex)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Key-entry / display bundle for seg_display_driver.
//   din, load, clear : key code and strobes from the keypad side
//   seg, dig_n, full : segment code, active-low digit enables, buffer-full flag
interface seg_display_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import seg_display_driver_pkg::*;

  logic [DIGIT_W-1:0]    din;
  logic                  load;
  logic                  clear;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig_n;
  logic                  full;

  modport master (output din, load, clear, input seg, dig_n, full);
  modport slave  (input din, load, clear, output seg, dig_n, full);

endinterface

// File: rtl/seg_display_driver_seg7_decoder.sv
// Combinational hex-to-7-segment decoder with blanking.
//   hex   : 4-bit digit value
//   blank : 1 forces all segments dark
//   seg   : {g,f,e,d,c,b,a}, 1 = lit
module seg_display_driver_seg7_decoder
  import seg_display_driver_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex,
  input  logic               blank,
  output logic [6:0]         seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_to_seg(hex);
  end

endmodule

// File: rtl/seg_display_driver.sv
// Calculator-style digit buffer driving a multiplexed common-cathode display.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of seg_display_driver_if (din/load/clear in,
//              seg/dig_n/full out, all outputs registered)
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          BLANK_LEAD = 1'b1
) (
  input logic                clk,
  input logic                rst,
  seg_display_driver_if.slave bus
);

  localparam int unsigned PtrW  = $clog2(NUM_DIGITS);
  localparam int unsigned CntW  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned PresW = $clog2(SCAN_DIV);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] buf_q, buf_d;
  logic [CntW-1:0]                    cnt_q, cnt_d;
  logic                               full_q;
  logic [PresW-1:0]                   presc_q, presc_d;
  // ptr_q is the next slot to show; slot_q is the slot currently on display.
  logic [PtrW-1:0]                    ptr_q, ptr_d, slot_q, slot_d, sel;
  logic                               active_q, tick, blank;
  logic [6:0]                         seg_q, seg_d, dec_seg;
  logic [NUM_DIGITS-1:0]              dig_n_q, dig_n_d;

  // Shift buffer: clear wins over load; count saturates at NUM_DIGITS.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (bus.clear) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (bus.load) begin
      buf_d = {buf_q[NUM_DIGITS-2:0], bus.din};
      if (cnt_q != CntW'(NUM_DIGITS)) cnt_d = cnt_q + CntW'(1);
    end
  end

  // Scan timing: the tick edge starts a slot with one dark cycle.
  always_comb begin
    tick    = (presc_q == PresW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + PresW'(1);
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    if (tick) begin
      slot_d = ptr_q;
      ptr_d  = (ptr_q == PtrW'(NUM_DIGITS - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  // Look ahead to the incoming slot so seg is ready during the dark cycle.
  always_comb begin
    sel   = tick ? ptr_q : slot_q;
    // Digit 0 is never blanked, so an empty buffer reads "0".
    blank = BLANK_LEAD && (sel != '0) && (CntW'(sel) >= cnt_q);
  end

  seg_display_driver_seg7_decoder u_decoder (
    .hex   (buf_q[sel]),
    .blank (blank),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_d   = (active_q || tick) ? dec_seg : SEG_BLANK;
    dig_n_d = '1;
    if (active_q && !tick) dig_n_d[slot_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      presc_q  <= '0;
      ptr_q    <= '0;
      slot_q   <= '0;
      active_q <= 1'b0;
      seg_q    <= SEG_BLANK;
      dig_n_q  <= '1;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CntW'(NUM_DIGITS));
      presc_q  <= presc_d;
      ptr_q    <= ptr_d;
      slot_q   <= slot_d;
      active_q <= active_q | tick;
      seg_q    <= seg_d;
      dig_n_q  <= dig_n_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dig_n = dig_n_q;
  assign bus.full  = full_q;

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

  localparam int N  = 4;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_display_driver_if #(.NUM_DIGITS(N)) bus ();

  seg_display_driver #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .BLANK_LEAD (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    string          tag;
    logic           chk_seg;
    logic [6:0]     seg;
    logic [N-1:0]   dig_n;
    logic           full;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  int           m_dig[N];
  int           m_cnt;
  int           m_cyc;
  logic [N-1:0] last_dig_n;
  string        phase;

  // Expected segments for slot s given the buffer as it stood before the edge.
  function automatic logic [6:0] model_seg(input int s);
    if (m_cnt == 0) return (s == 0) ? hex_tab[0] : 7'h00;
    return (s < m_cnt) ? hex_tab[m_dig[s]] : 7'h00;
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic c, input logic [3:0] d);
    exp_t e;
    int   s;
    e.tag     = phase;
    e.chk_seg = 1'b1;
    e.seg     = 7'h00;
    e.dig_n   = '1;
    if (r) begin
      m_cyc = 0;
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_dig[i] = 0;
      e.full = 1'b0;
    end else begin
      m_cyc++;
      if (m_cyc >= SD + 1 && (m_cyc - SD) % SD != 0) begin
        s          = ((m_cyc - SD) / SD) % N;
        e.dig_n[s] = 1'b0;
        e.seg      = model_seg(s);
      end else begin
        e.chk_seg = (m_cyc < SD);
      end
      if (c) begin
        m_cnt = 0;
        for (int i = 0; i < N; i++) m_dig[i] = 0;
      end else if (l) begin
        for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
        m_dig[0] = int'(d);
        if (m_cnt < N) m_cnt++;
      end
      e.full = (m_cnt == N);
    end
    last_dig_n = e.dig_n;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got size %0d want >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus.dig_n === e.dig_n) else begin
        errors++;
        $error("FAIL %s dig_n: got %b want %b (cyc %0d)", e.tag, bus.dig_n, e.dig_n, m_cyc);
      end
      checks++;
      assert (bus.full === e.full) else begin
        errors++;
        $error("FAIL %s full: got %b want %b (cyc %0d)", e.tag, bus.full, e.full, m_cyc);
      end
      if (e.chk_seg) begin
        checks++;
        assert (bus.seg === e.seg) else begin
          errors++;
          $error("FAIL %s seg: got %h want %h (cyc %0d)", e.tag, bus.seg, e.seg, m_cyc);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic c, input logic [3:0] d);
    rst      = r;
    bus.load = l;
    bus.clear = c;
    bus.din  = d;
    @(posedge clk);
    model_edge(r, l, c, d);
    #1;
    check_pop();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    bit found;
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.clear = 1'b0;
    bus.din   = 4'h0;
    m_cyc     = 0;
    m_cnt     = 0;

    phase = "reset";
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);

    phase = "idle_scan";
    idle(22);

    phase = "load_123";
    step(1'b0, 1'b1, 1'b0, 4'h1);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 4'h2);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 4'h3);
    idle(18);

    phase = "load_AtoE";
    step(1'b0, 1'b1, 1'b0, 4'hA);
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b0, 1'b1, 1'b0, 4'hC);
    step(1'b0, 1'b1, 1'b0, 4'hD);
    step(1'b0, 1'b1, 1'b0, 4'hE);
    idle(18);

    phase = "clear_load";
    step(1'b0, 1'b1, 1'b1, 4'h7);
    idle(18);

    // Land a load exactly on a tick cycle (prescaler at SD-1).
    phase = "load_on_tick";
    for (int k = 0; k < SD && (m_cyc % SD) != SD - 1; k++) idle(1);
    step(1'b0, 1'b1, 1'b0, 4'h5);
    idle(18);

    phase = "reset_mid_scan";
    step(1'b0, 1'b1, 1'b0, 4'h9);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h7);
    step(1'b0, 1'b1, 1'b0, 4'h6);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      idle(1);
      if (last_dig_n == 4'b1011) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL reset_mid_scan_wait: got no dig_n=1011 want dig_n=1011 within 40 cycles");
    end
    step(1'b1, 1'b0, 1'b0, 4'h0);
    phase = "restart_scan";
    idle(22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
